// File: rtl/alu_serial_responder.sv
// alu_serial_responder: word-level ALU responder.
// Collects MIN_ARGS..MAX_ARGS data words and then one command word. It folds
// the buffered operand bytes into a 16-bit accumulator, one operand per cycle,
// and returns three words: status, result high byte and result low byte.
// Words are {type, payload[7:0], even parity}.
// Optional feature macro: ALU_MUL_EN adds command 0x06 (MUL).
//
// Handshakes: a word moves on a rising clk edge when valid && ready are both
// high. A producer holds valid and its word stable until that edge.
// out_word/out_valid are registered. in_ready is a decode of the state
// register.
module alu_serial_responder #(
  parameter int MAX_ARGS = 9,
  parameter int MIN_ARGS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] in_word,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] out_word,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int CW = $clog2(MAX_ARGS + 2);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_CALC     = 3'd2;
  localparam logic [2:0] ST_SEND_STS = 3'd3;
  localparam logic [2:0] ST_SEND_HI  = 3'd4;
  localparam logic [2:0] ST_SEND_LO  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [7:0]    arg_q [MAX_ARGS];
  logic [7:0]    arg_d [MAX_ARGS];
  logic [7:0]    op_q, op_d;
  logic [15:0]   acc_q, acc_d;
  logic          argerr_q, argerr_d;   // overflow beyond MAX_ARGS
  logic          parerr_q, parerr_d;   // any bad parity seen so far
  logic [2:0]    err_q, err_d;         // final {PARITY, ARGNUM, INVCMD}
  logic [9:0]    out_word_q, out_word_d;
  logic          out_valid_q, out_valid_d;

  logic in_fire;
  logic out_fire;
  logic par_bad;

  // Build a protocol word with its even-parity bit.
  function automatic logic [9:0] mk_word(input logic t, input logic [7:0] b);
    return {t, b, ^{t, b}};
  endfunction

  // Reports whether an opcode is outside the supported set.
  function automatic logic cmd_invalid(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05: return 1'b0;
`ifdef ALU_MUL_EN
      8'h06: return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

  // Applies one accumulator step. The byte operand is zero-extended and the
  // result wraps modulo 2^16.
  function automatic logic [15:0] alu_step(input logic [7:0] op, input logic [15:0] a,
                                           input logic [7:0] b);
    logic [15:0] bz;
    bz = {8'h00, b};
    case (op)
      8'h01:   return a & bz;
      8'h02:   return a | bz;
      8'h03:   return a ^ bz;
      8'h04:   return a + bz;
      8'h05:   return a - bz;
`ifdef ALU_MUL_EN
      8'h06:   return a * bz;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  assign in_ready  = (state_q == ST_COLLECT);
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign par_bad   = ^in_word;

  // Compute the next state, the operand buffer and the response registers.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    op_d        = op_q;
    acc_d       = acc_q;
    argerr_d    = argerr_q;
    parerr_d    = parerr_q;
    err_d       = err_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (in_fire) begin
          if (par_bad) parerr_d = 1'b1;
          if (!in_word[9]) begin
            if (count_q < CW'(MAX_ARGS)) begin
              arg_d[count_q] = in_word[8:1];
              count_d        = count_q + CW'(1);
            end else begin
              argerr_d = 1'b1;
              count_d  = CW'(MAX_ARGS + 1);
            end
          end else begin
            op_d    = in_word[8:1];
            err_d   = {parerr_q | par_bad,
                       argerr_q | (count_q < CW'(MIN_ARGS)) | (count_q > CW'(MAX_ARGS)),
                       cmd_invalid(in_word[8:1])};
            acc_d   = {8'h00, arg_q[0]};
            idx_d   = CW'(1);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (err_q != 3'b000) begin
          // An erroneous transaction spends one cycle here and returns 0.
          acc_d   = 16'h0000;
          state_d = ST_SEND_STS;
        end else begin
          acc_d = alu_step(op_q, acc_q, arg_q[idx_q]);
          idx_d = idx_q + CW'(1);
          if (idx_q == count_q - CW'(1)) state_d = ST_SEND_STS;
        end
      end
      ST_SEND_STS: begin
        // The first cycle here loads the status word. Later cycles wait
        // for the sink to take it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_word_d  = mk_word(1'b1, {5'b00000, err_q});
        end else if (out_fire) begin
          out_word_d = mk_word(1'b0, acc_q[15:8]);
          state_d    = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (out_fire) begin
          out_word_d = mk_word(1'b0, acc_q[7:0]);
          state_d    = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          count_d     = '0;
          argerr_d    = 1'b0;
          parerr_d    = 1'b0;
          err_d       = 3'b000;
          state_d     = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register all state. Reset abandons any transaction that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      for (int i = 0; i < MAX_ARGS; i++) arg_q[i] <= 8'h00;
      op_q        <= 8'h00;
      acc_q       <= 16'h0000;
      argerr_q    <= 1'b0;
      parerr_q    <= 1'b0;
      err_q       <= 3'b000;
      out_word_q  <= 10'h000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      argerr_q    <= argerr_d;
      parerr_q    <= parerr_d;
      err_q       <= err_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Bench for alu_serial_responder. Directed transactions push their
// hand-computed response words and latency into queues. A negedge monitor pops
// and compares whenever the DUT presents a word.
module tb_alu_serial_responder;

  logic       clk;
  logic       rst_n;
  logic [9:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_word;
  logic       out_valid;
  logic       out_ready;

  alu_serial_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int         exp_lat_q[$];
  logic [7:0] args_q[$];
  int         cmd_cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic       prev_valid = 1'b0;

  function automatic logic [9:0] mk(input logic t, input logic [7:0] b);
    return {t, b, ^{t, b}};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (exp_lat_q.size() == 0) chk("unexpected_valid_rise", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - cmd_cyc), 32'(exp_lat_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {22'd0, out_word}, 32'h3ff);
        else chk("out_word", {22'd0, out_word}, {22'd0, exp_q.pop_front()});
      end
    end
    prev_valid = out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [9:0] w, input logic is_cmd);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (is_cmd) cmd_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Sends args_q (optionally with one parity bit flipped) and then the command.
  task automatic issue(input logic [7:0] cmd, input int flip, input logic [7:0] est,
                       input logic [15:0] eres, input int elat, input logic push);
    logic [9:0] w;
    if (push) begin
      exp_q.push_back(mk(1'b1, est));
      exp_q.push_back(mk(1'b0, eres[15:8]));
      exp_q.push_back(mk(1'b0, eres[7:0]));
      exp_lat_q.push_back(elat);
    end
    foreach (args_q[i]) begin
      w = mk(1'b0, args_q[i]);
      if (i == flip) w[0] = ~w[0];
      send_word(w, 1'b0);
    end
    send_word(mk(1'b1, cmd), 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("response_timeout", 32'd0, 32'd1);
    chk("latency_queue_drained", 32'(exp_lat_q.size()), 32'd0);
    exp_q.delete();
    exp_lat_q.delete();
  endtask

  task automatic txn(input logic [7:0] cmd, input int flip, input logic [7:0] est,
                     input logic [15:0] eres, input int elat);
    issue(cmd, flip, est, eres, elat, 1'b1);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 10'h000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", {22'd0, out_word}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_edge_in_ready", {31'd0, in_ready}, 32'd1);

    args_q = '{8'hFF, 8'h01};             txn(8'h04, -1, 8'h00, 16'h0100, 2);
    args_q = '{8'h05, 8'h07};             txn(8'h05, -1, 8'h00, 16'hFFFE, 2);
    args_q = '{8'hF0, 8'h3C, 8'hFF};      txn(8'h01, -1, 8'h00, 16'h0030, 3);
    args_q = '{8'h12, 8'h34, 8'h40};      txn(8'h02, -1, 8'h00, 16'h0076, 3);
    args_q = '{8'hAA, 8'h0F};             txn(8'h03, -1, 8'h00, 16'h00A5, 2);
    args_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    txn(8'h04, -1, 8'h00, 16'h08F7, 9);
    args_q = '{8'h11, 8'h22};             txn(8'h7F, -1, 8'h01, 16'h0000, 2);
    args_q = '{8'h11};                    txn(8'h04, -1, 8'h02, 16'h0000, 2);
    args_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    txn(8'h04, -1, 8'h02, 16'h0000, 2);
    args_q = '{8'h11, 8'h22, 8'h33};      txn(8'h7F, 1, 8'h05, 16'h0000, 2);
    args_q = '{8'h10, 8'h20};             txn(8'h04, -1, 8'h00, 16'h0030, 2);

    // Sink stalls while the high byte is on offer.
    args_q = '{8'h80, 8'h90};
    issue(8'h04, -1, 8'h00, 16'h0110, 2, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("stall_wait_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hi_word", {22'd0, out_word}, {22'd0, mk(1'b0, 8'h01)});
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_done();

    // Reset pulse while a 9-operand ADD is still accumulating.
    args_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    issue(8'h04, -1, 8'h00, 16'h0009, 9, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_word", {22'd0, out_word}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    args_q = '{8'h01, 8'h02};             txn(8'h04, -1, 8'h00, 16'h0003, 2);

`ifdef ALU_MUL_EN
    args_q = '{8'h10, 8'h20};             txn(8'h06, -1, 8'h00, 16'h0200, 2);
`else
    args_q = '{8'h10, 8'h20};             txn(8'h06, -1, 8'h01, 16'h0000, 2);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
